fifo_wr_arbiter: RTL and testbench

- Round-robin write arbiter that shares the write port of one single-clock FIFO (8-bit data path) between NREQ requesters.
- Each requester presents a valid/ready stream. The arbiter grants one requester at a time for a bounded burst.
- It throttles on the FIFO's full and almost-full flags and drives registered fifo_we/fifo_din directly into the FIFO write port.

---
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter in front of a single-clock FIFO write port
// Define FIFO_WR_ARB_PRIO_EN to make requester 0 strict high priority with unlimited bursts.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               fifo_full,
    input  logic               fifo_full_n,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_din,
    output logic [NREQ-1:0]    grant,
    output logic               busy
);
    localparam int PW  = $clog2(NREQ);
    localparam int BCW = $clog2(BURST) + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [BCW-1:0]  beat_cnt;

    logic            stall;
    logic            accept;
    logic            last_beat;
    logic            bubble;
    logic            release_now;
    logic            found;
    logic [PW-1:0]   sel;
    logic [PW:0]     scan;
    logic [PW-1:0]   next_ptr;
    logic [DW-1:0]   owner_data;

    // A registered write may still be landing when almost-full is seen, so treat that as full.
    assign stall       = fifo_full | (fifo_full_n & fifo_we);
    assign req_ready   = grant & {NREQ{~stall}};
    assign accept      = |(req_valid & req_ready);
    assign busy        = (state == GRANT);
    assign bubble      = ~req_valid[owner] & ~stall;
    assign next_ptr    = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

`ifdef FIFO_WR_ARB_PRIO_EN
    assign last_beat   = (beat_cnt == BCW'(BURST - 1)) && (owner != '0);
`else
    assign last_beat   = (beat_cnt == BCW'(BURST - 1));
`endif
    assign release_now = (accept & last_beat) | bubble;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        scan  = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + (PW + 1)'(i);
            if (scan >= (PW + 1)'(NREQ))
                scan = scan - (PW + 1)'(NREQ);
            if (!found && req_valid[scan[PW-1:0]]) begin
                sel   = scan[PW-1:0];
                found = 1'b1;
            end
        end
`ifdef FIFO_WR_ARB_PRIO_EN
        if (req_valid[0])
            sel = '0;
`endif
    end

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (owner == PW'(i))
                owner_data = req_data[i*DW +: DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            fifo_we  <= 1'b0;
            fifo_din <= '0;
        end else if (state == IDLE) begin
            fifo_we <= 1'b0;
            if (found && !fifo_full) begin
                grant    <= NREQ'(1) << sel;
                owner    <= sel;
                beat_cnt <= '0;
                state    <= GRANT;
            end
        end else begin
            fifo_we <= accept;
            if (accept) begin
                fifo_din <= owner_data;
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (release_now) begin
                state <= IDLE;
                grant <= '0;
`ifdef FIFO_WR_ARB_PRIO_EN
                if (owner != '0)
                    rr_ptr <= next_ptr;
`else
                rr_ptr <= next_ptr;
`endif
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_full_n;
    logic               fifo_we;
    logic [DW-1:0]      fifo_din;
    logic [NREQ-1:0]    grant;
    logic               busy;

    int errors = 0;
    int checks = 0;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .fifo_full(fifo_full), .fifo_full_n(fifo_full_n),
        .fifo_we(fifo_we), .fifo_din(fifo_din),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] d);
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_valid   = '0;
        fifo_full   = 1'b0;
        fifo_full_n = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        fifo_full   = 1'b0;
        fifo_full_n = 1'b0;
        @(negedge clk);
        #1;
        check("rst fifo_we", 32'(fifo_we), 0);
        check("rst fifo_din", 32'(fifo_din), 0);
        check("rst grant", 32'(grant), 0);
        check("rst busy", 32'(busy), 0);
        check("rst req_ready", 32'(req_ready), 0);
        check("rst rr_ptr", 32'(dut.rr_ptr), 0);

        // Single requester, three back-to-back beats
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'h11);
        tick();
        #1;
        check("t1 grant", 32'(grant), 32'h2);
        check("t1 busy", 32'(busy), 1);
        check("t1 we arb", 32'(fifo_we), 0);
        check("t1 ready", 32'(req_ready), 32'h2);
        tick();
        check("t1 we b0", 32'(fifo_we), 1);
        check("t1 din b0", 32'(fifo_din), 32'h11);
        set_data(1, 8'h22);
        tick();
        check("t1 we b1", 32'(fifo_we), 1);
        check("t1 din b1", 32'(fifo_din), 32'h22);
        set_data(1, 8'h33);
        tick();
        check("t1 we b2", 32'(fifo_we), 1);
        check("t1 din b2", 32'(fifo_din), 32'h33);
        req_valid = '0;
        tick();
        check("t1 we end", 32'(fifo_we), 0);
        check("t1 grant end", 32'(grant), 0);
        check("t1 busy end", 32'(busy), 0);
        check("t1 rr_ptr", 32'(dut.rr_ptr), 2);

        // All requesters continuously valid: bursts of BURST in round-robin order
        do_reset();
        req_valid = 4'hF;
        for (int b = 0; b < 5; b++) begin
            check($sformatf("t2 idle grant b%0d", b), 32'(grant), 0);
            tick();
            check($sformatf("t2 first we b%0d", b), 32'(fifo_we), 0);
            for (int k = 0; k < BURST; k++) begin
                set_data(b % NREQ, 8'(b * 16 + k));
                #1;
                check($sformatf("t2 grant b%0d k%0d", b, k), 32'(grant), 32'(1) << (b % NREQ));
                check($sformatf("t2 ready b%0d k%0d", b, k), 32'(req_ready), 32'(1) << (b % NREQ));
                tick();
                check($sformatf("t2 we b%0d k%0d", b, k), 32'(fifo_we), 1);
                check($sformatf("t2 din b%0d k%0d", b, k), 32'(fifo_din), 32'(b * 16 + k));
            end
        end
        req_valid = '0;
        tick();

        // Full / almost-full throttling mid-burst
        do_reset();
        req_valid = 4'b0100;
        fifo_full = 1'b1;
        set_data(2, 8'hA0);
        tick();
        check("t3 no arb while full", 32'(grant), 0);
        fifo_full = 1'b0;
        tick();
        #1;
        check("t3 grant", 32'(grant), 32'h4);
        check("t3 ready", 32'(req_ready), 32'h4);
        tick();
        check("t3 we b0", 32'(fifo_we), 1);
        check("t3 din b0", 32'(fifo_din), 32'hA0);
        fifo_full_n = 1'b1;
        set_data(2, 8'hA1);
        #1;
        check("t3 ready almost-full", 32'(req_ready), 0);
        tick();
        check("t3 we stalled", 32'(fifo_we), 0);
        check("t3 din hold", 32'(fifo_din), 32'hA0);
        fifo_full = 1'b1;
        #1;
        check("t3 ready full", 32'(req_ready), 0);
        tick();
        check("t3 we full", 32'(fifo_we), 0);
        check("t3 grant kept", 32'(grant), 32'h4);
        fifo_full   = 1'b0;
        fifo_full_n = 1'b0;
        #1;
        check("t3 ready resume", 32'(req_ready), 32'h4);
        tick();
        check("t3 we b1", 32'(fifo_we), 1);
        check("t3 din b1", 32'(fifo_din), 32'hA1);
        req_valid   = '0;
        fifo_full_n = 1'b1;
        tick();
        check("t3 stalled bubble keeps grant", 32'(grant), 32'h4);
        check("t3 busy", 32'(busy), 1);
        check("t3 we none", 32'(fifo_we), 0);
        tick();
        check("t3 released", 32'(grant), 0);
        check("t3 rr_ptr", 32'(dut.rr_ptr), 3);
        fifo_full_n = 1'b0;

        // Owner bubble after two beats ends the burst early
        do_reset();
        req_valid = 4'b0011;
        tick();
        check("t4 grant0", 32'(grant), 32'h1);
        tick();
        check("t4 we b0", 32'(fifo_we), 1);
        tick();
        check("t4 we b1", 32'(fifo_we), 1);
        req_valid = 4'b0010;
        tick();
        check("t4 release", 32'(grant), 0);
        check("t4 rr_ptr", 32'(dut.rr_ptr), 1);
        check("t4 we idle", 32'(fifo_we), 0);
        tick();
        check("t4 grant1", 32'(grant), 32'h2);
        req_valid = '0;
        tick();
        check("t4 release1", 32'(grant), 0);
        check("t4 rr_ptr1", 32'(dut.rr_ptr), 2);

        // Asynchronous reset mid-burst
        do_reset();
        req_valid = 4'b0010;
        tick();
        tick();
        tick();
        check("t5 we before rst", 32'(fifo_we), 1);
        check("t5 grant before rst", 32'(grant), 32'h2);
        rst = 1'b1;
        #1;
        check("t5 async we", 32'(fifo_we), 0);
        check("t5 async grant", 32'(grant), 0);
        check("t5 async busy", 32'(busy), 0);
        req_valid = 4'b0101;
        tick();
        check("t5 grant in rst", 32'(grant), 0);
        rst = 1'b0;
        tick();
        check("t5 req0 first", 32'(grant), 32'h1);

        // rr_ptr=3 with requesters 0 and 3 pending
        do_reset();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        check("t6 rr_ptr", 32'(dut.rr_ptr), 3);
        req_valid = 4'b1001;
        tick();
`ifdef FIFO_WR_ARB_PRIO_EN
        check("t6 prio grant", 32'(grant), 32'h1);
        for (int k = 0; k < 8; k++) begin
            set_data(0, 8'(8'hC0 + k));
            tick();
            check($sformatf("t6 we k%0d", k), 32'(fifo_we), 1);
            check($sformatf("t6 din k%0d", k), 32'(fifo_din), 32'(8'hC0 + k));
            check($sformatf("t6 grant k%0d", k), 32'(grant), 32'h1);
        end
        req_valid = 4'b1000;
        tick();
        check("t6 prio release", 32'(grant), 0);
        check("t6 prio rr_ptr", 32'(dut.rr_ptr), 3);
        tick();
        check("t6 req3 after", 32'(grant), 32'h8);
`else
        check("t6 rr grant3", 32'(grant), 32'h8);
        req_valid = '0;
        tick();
        check("t6 wrap rr_ptr", 32'(dut.rr_ptr), 0);
        check("t6 released", 32'(grant), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
